// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF measurement sequencer: runs each RO for a fixed window,
// captures its edge count, then builds the adjacent-pair comparison response.
//
// state     | meaning
// S_IDLE    | waiting for start; ro_sel parked at 0
// S_CLEAR   | edge counter cleared, window timer loaded
// S_MEASURE | selected RO enabled for WINDOW cycles
// S_SETTLE  | RO stopped, counter quiescing for SETTLE cycles
// S_CAPTURE | store ro_count for ro_sel, advance or finish
// S_COMPARE | build response from adjacent stored counts
// S_DONE    | done pulse, response valid
module ro_puf_sequencer #(
    parameter int NUM_RO = 9,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 65536,
    parameter int SETTLE = 4,
    parameter int SEL_W  = 4
) (
    input  logic              count_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        challenge,
    input  logic [CNT_W-1:0]  ro_count,
    output logic [7:0]        chal_q,
    output logic [SEL_W-1:0]  ro_sel,
    output logic              ro_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic              resp_valid,
    output logic [NUM_RO-2:0] response
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MEASURE, S_SETTLE, S_CAPTURE, S_COMPARE, S_DONE
    } state_t;

    state_t           state, state_next;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] counts [NUM_RO];
    logic             timer_tc;
    logic             last_ro;

    assign timer_tc = (timer == '0);
    assign last_ro  = (ro_sel == SEL_W'(NUM_RO - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_MEASURE;
            S_MEASURE: if (timer_tc) state_next = S_SETTLE;
            S_SETTLE:  if (timer_tc) state_next = S_CAPTURE;
            S_CAPTURE: state_next = last_ro ? S_COMPARE : S_CLEAR;
            S_COMPARE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            chal_q     <= '0;
            ro_sel     <= '0;
            ro_en      <= 1'b0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            for (int i = 0; i < NUM_RO; i++) counts[i] <= '0;
        end else begin
            state   <= state_next;
            ro_en   <= (state_next == S_MEASURE);
            cnt_clr <= (state_next == S_CLEAR);
            busy    <= (state_next != S_IDLE);
            done    <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_q     <= challenge;
                        ro_sel     <= '0;
                        resp_valid <= 1'b0;
                    end
                end
                S_CLEAR: timer <= TW'(WINDOW - 1);
                S_MEASURE: begin
                    if (timer_tc) timer <= TW'(SETTLE - 1);
                    else          timer <= timer - 1'b1;
                end
                S_SETTLE: begin
                    if (!timer_tc) timer <= timer - 1'b1;
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NUM_RO; i++) begin
                        if (ro_sel == SEL_W'(i)) counts[i] <= ro_count;
                    end
                    if (!last_ro) ro_sel <= ro_sel + SEL_W'(1);
                end
                S_COMPARE: begin
                    for (int i = 0; i < NUM_RO - 1; i++) begin
                        response[i] <= (counts[i+1] > counts[i]);
                    end
                    resp_valid <= 1'b1;
                end
                S_DONE: ro_sel <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer: table-driven full runs plus
// handshake and mid-run reset sequences, with a protocol monitor.
module tb_ro_puf_sequencer;

    localparam int NUM_RO  = 9;
    localparam int CNT_W   = 16;
    localparam int WINDOW  = 16;
    localparam int SETTLE  = 4;
    localparam int SEL_W   = 4;
    localparam int RUN_CYC = 200;

    logic              count_clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        challenge;
    logic [CNT_W-1:0]  ro_count;
    logic [7:0]        chal_q;
    logic [SEL_W-1:0]  ro_sel;
    logic              ro_en;
    logic              cnt_clr;
    logic              busy;
    logic              done;
    logic              resp_valid;
    logic [NUM_RO-2:0] response;

    logic [CNT_W-1:0]  cnt_tab [16];

    int checks = 0;
    int errors = 0;

    ro_puf_sequencer #(
        .NUM_RO(NUM_RO), .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE), .SEL_W(SEL_W)
    ) dut (
        .count_clk (count_clk),
        .reset     (reset),
        .start     (start),
        .challenge (challenge),
        .ro_count  (ro_count),
        .chal_q    (chal_q),
        .ro_sel    (ro_sel),
        .ro_en     (ro_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .resp_valid(resp_valid),
        .response  (response)
    );

    always #5 count_clk = ~count_clk;

    // Edge-counter model: returns the programmed count for whichever RO is selected.
    assign ro_count = cnt_tab[ro_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int         en_pulses = 0;
    int         clr_pulses = 0;
    int         bad_width = 0;
    int         bad_order = 0;
    int         bad_clr = 0;
    int         bad_excl = 0;
    int         en_len = 0;
    logic       prev_en = 1'b0;
    logic       prev_clr = 1'b0;
    logic [3:0] exp_sel = 4'd0;

    always begin
        @(posedge count_clk);
        #2;
        if (reset) begin
            prev_en  = 1'b0;
            prev_clr = 1'b0;
            en_len   = 0;
            exp_sel  = 4'd0;
        end else begin
            if (!busy) exp_sel = 4'd0;
            if (ro_en && (cnt_clr || !busy)) bad_excl++;
            if (cnt_clr) begin
                clr_pulses++;
                if (prev_clr) bad_clr++;
            end
            if (ro_en && !prev_en) begin
                en_pulses++;
                if (!prev_clr) bad_clr++;
                if (ro_sel !== exp_sel) bad_order++;
                exp_sel = exp_sel + 4'd1;
                en_len = 1;
            end else if (ro_en) begin
                en_len++;
            end else if (prev_en && en_len != WINDOW) begin
                bad_width++;
            end
            prev_en  = ro_en;
            prev_clr = cnt_clr;
        end
    end

    typedef struct {
        string        tag;
        logic [7:0]   chal;
        logic [143:0] counts;
        logic [7:0]   resp;
    } vec_t;

    vec_t vecs [5];

    task automatic run(input string tag, input logic [7:0] chal, input logic [143:0] counts,
                       input logic [7:0] exp_resp, input bit disturb);
        int n;
        int s_en, s_clr, s_w, s_o, s_c, s_x;
        bit chal_bad, busy_bad;
        @(negedge count_clk);
        for (int i = 0; i < NUM_RO; i++) cnt_tab[i] = counts[i*16 +: 16];
        s_en = en_pulses; s_clr = clr_pulses; s_w = bad_width;
        s_o = bad_order;  s_c = bad_clr;      s_x = bad_excl;
        challenge = chal;
        start = 1'b1;
        @(negedge count_clk);
        start = 1'b0;
        check({tag, " resp_valid cleared on accept"}, 32'(resp_valid), 32'd0);
        n = 1;
        chal_bad = 1'b0;
        busy_bad = 1'b0;
        while (!done && n < 400) begin
            if (chal_q !== chal) chal_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (disturb && (n == 50 || n == 120)) begin
                start = 1'b1;
                challenge = 8'h3C;
            end else begin
                start = 1'b0;
            end
            @(negedge count_clk);
            n++;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(done), 32'd1);
        check({tag, " done cycle"}, 32'(n), 32'(RUN_CYC));
        check({tag, " chal_q held"}, 32'(chal_bad), 32'd0);
        check({tag, " busy during run"}, 32'(busy_bad), 32'd0);
        check({tag, " busy in done"}, 32'(busy), 32'd1);
        check({tag, " response"}, 32'(response), 32'(exp_resp));
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        @(negedge count_clk);
        check({tag, " done one cycle"}, 32'({done, busy, resp_valid}), 32'b001);
        check({tag, " ro_sel parked"}, 32'(ro_sel), 32'd0);
        check({tag, " response held"}, 32'(response), 32'(exp_resp));
        check({tag, " enable pulses"}, 32'(en_pulses - s_en), 32'(NUM_RO));
        check({tag, " clear pulses"}, 32'(clr_pulses - s_clr), 32'(NUM_RO));
        check({tag, " enable width"}, 32'(bad_width - s_w), 32'd0);
        check({tag, " ro_sel order"}, 32'(bad_order - s_o), 32'd0);
        check({tag, " clear before enable"}, 32'(bad_clr - s_c), 32'd0);
        check({tag, " en/clr exclusive"}, 32'(bad_excl - s_x), 32'd0);
    endtask

    initial begin
        bit   idle_bad;
        bit   queued;
        bit   found;
        int   n;

        vecs[0] = '{"spec counts", 8'hA5,
                    {16'd0, 16'd41, 16'd40, 16'd5, 16'd30, 16'd15, 16'd15, 16'd20, 16'd10}, 8'h69};
        vecs[1] = '{"all equal max", 8'h5A,
                    {9{16'hFFFF}}, 8'h00};
        vecs[2] = '{"increasing", 8'hC3,
                    {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 8'hFF};
        vecs[3] = '{"alternating", 8'h0F,
                    {16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF}, 8'hAA};
        vecs[4] = '{"mixed unsigned", 8'h96,
                    {16'h7FFF, 16'h8000, 16'd99, 16'd100, 16'd6, 16'd8, 16'd8, 16'd7, 16'd7}, 8'h52};

        for (int i = 0; i < 16; i++) cnt_tab[i] = '0;
        reset = 1'b1;
        start = 1'b0;
        challenge = 8'h00;
        repeat (3) @(negedge count_clk);
        check("outputs in reset",
              32'({chal_q, ro_sel, ro_en, cnt_clr, busy, done, resp_valid, response}), 32'd0);
        reset = 1'b0;
        idle_bad = 1'b0;
        repeat (10) begin
            @(negedge count_clk);
            if ({chal_q, ro_sel, ro_en, cnt_clr, busy, done, resp_valid, response} !== '0)
                idle_bad = 1'b1;
        end
        check("idle outputs zero", 32'(idle_bad), 32'd0);

        for (int v = 0; v < 5; v++) run(vecs[v].tag, vecs[v].chal, vecs[v].counts, vecs[v].resp, 1'b0);

        run("handshake", 8'hA5, vecs[0].counts, 8'h69, 1'b1);
        queued = 1'b0;
        repeat (5) begin
            @(negedge count_clk);
            if (busy !== 1'b0) queued = 1'b1;
        end
        check("no queued start", 32'(queued), 32'd0);
        check("chal_q after ignored change", 32'(chal_q), 32'hA5);
        check("resp_valid held in idle", 32'(resp_valid), 32'd1);
        run("second run", 8'h3C, vecs[2].counts, 8'hFF, 1'b0);

        @(negedge count_clk);
        for (int i = 0; i < NUM_RO; i++) cnt_tab[i] = vecs[0].counts[i*16 +: 16];
        challenge = 8'h77;
        start = 1'b1;
        @(negedge count_clk);
        start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            if (ro_en && ro_sel == 4'd4) found = 1'b1;
            else begin
                @(negedge count_clk);
                n++;
            end
        end
        check("reached measure of ro 4", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async abort outputs", 32'({ro_en, cnt_clr, busy, done, resp_valid}), 32'd0);
        check("async abort ro_sel", 32'(ro_sel), 32'd0);
        check("async abort chal_q", 32'(chal_q), 32'd0);
        @(negedge count_clk);
        reset = 1'b0;
        run("after reset", 8'h77, vecs[0].counts, 8'h69, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
